// File: rtl/demux1n2_buf.sv
// ----------------------------------------------------------------------------
// demux1n2_buf
//   Buffered 1-to-2 demultiplexer for the 24-bit write-back datapath.
//   One valid/ready input stream is steered beat-by-beat to one of two output
//   streams by InSel. Each output owns a small FIFO, so a stalled sink only
//   blocks the input when the next beat is aimed at that sink.
//
// Parameters
//   Width : payload width in bits
//   Depth : entries per output FIFO (power of two, >= 2)
//
// Ports
//   Clock                  rising-edge clock
//   Reset                  synchronous, active-low reset
//   InValid/InReady/InData input stream; InSel picks the destination (0/1)
//   Out0Valid/Ready/Data   output stream 0 (FIFO 0 head)
//   Out1Valid/Ready/Data   output stream 1 (FIFO 1 head)
//   Count0/Count1          completed pops per port, saturating
//                          (only when DEMUX_STATS_EN is defined)
//
// Optional feature macro: DEMUX_STATS_EN
// ----------------------------------------------------------------------------
module demux1n2_buf #(
    parameter int Width = 24,
    parameter int Depth = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [Width-1:0] InData,
    input  logic             InSel,
    output logic             Out0Valid,
    input  logic             Out0Ready,
    output logic [Width-1:0] Out0Data,
    output logic             Out1Valid,
    input  logic             Out1Ready,
    output logic [Width-1:0] Out1Data
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      Count0,
    output logic [15:0]      Count1
`endif
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    typedef logic [Width-1:0] word_t;

    word_t         mem_q   [2][Depth];
    word_t         mem_d   [2][Depth];
    logic [PW-1:0] wr_ptr_q[2];
    logic [PW-1:0] wr_ptr_d[2];
    logic [PW-1:0] rd_ptr_q[2];
    logic [PW-1:0] rd_ptr_d[2];
    logic [CW-1:0] count_q [2];
    logic [CW-1:0] count_d [2];

    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    out_ready;
    logic          in_ready;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        out_ready = {Out1Ready, Out0Ready};
        full      = '0;
        empty     = '0;
        push      = '0;
        pop       = '0;
        mem_d     = mem_q;
        for (int k = 0; k < 2; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            count_d[k]  = count_q[k];
            full[k]     = (count_q[k] == CW'(Depth));
            empty[k]    = (count_q[k] == '0);
        end

        // Readiness looks only at the selected FIFO's registered occupancy;
        // the sinks' ready inputs never feed back to InReady, so a full FIFO
        // refuses a push even in a cycle where it is also being popped.
        in_ready = Reset && !full[InSel];

        for (int k = 0; k < 2; k++) begin
            push[k] = InValid && in_ready && (int'(InSel) == k);
            pop[k]  = !empty[k] && out_ready[k];

            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = InData;
                wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   count_d[k] = count_q[k] + CW'(1);
                2'b01:   count_d[k] = count_q[k] - CW'(1);
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the values from before this edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
        end
    end

    // NOTE: storage is deliberately not reset; clearing the counters makes
    // every entry unreachable, and leaving the array resetless keeps it
    // mappable to plain RAM/flops without reset fan-out.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign InReady   = in_ready;
    assign Out0Valid = !empty[0];
    assign Out1Valid = !empty[1];
    assign Out0Data  = mem_q[0][rd_ptr_q[0]];
    assign Out1Data  = mem_q[1][rd_ptr_q[1]];

`ifdef DEMUX_STATS_EN
    logic [15:0] stat_q[2];
    logic [15:0] stat_d[2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            stat_d[k] = stat_q[k];
            if (pop[k] && (stat_q[k] != 16'hFFFF)) begin
                stat_d[k] = stat_q[k] + 16'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int k = 0; k < 2; k++) begin
                stat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                stat_q[k] <= stat_d[k];
            end
        end
    end

    assign Count0 = stat_q[0];
    assign Count1 = stat_q[1];
`endif

endmodule

// File: tb/tb_demux1n2_buf.sv
// ----------------------------------------------------------------------------
// tb_demux1n2_buf
//   Directed bench for demux1n2_buf. Inputs change 1 time unit after a rising
//   edge and outputs are sampled at that same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_demux1n2_buf;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [23:0] InData;
    logic        InSel;
    logic        Out0Valid;
    logic        Out0Ready;
    logic [23:0] Out0Data;
    logic        Out1Valid;
    logic        Out1Ready;
    logic [23:0] Out1Data;
`ifdef DEMUX_STATS_EN
    logic [15:0] Count0;
    logic [15:0] Count1;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 Clock = ~Clock;

    demux1n2_buf #(.Width(24), .Depth(2)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .InSel    (InSel),
        .Out0Valid(Out0Valid),
        .Out0Ready(Out0Ready),
        .Out0Data (Out0Data),
        .Out1Valid(Out1Valid),
        .Out1Ready(Out1Ready),
        .Out1Data (Out1Data)
`ifdef DEMUX_STATS_EN
        ,
        .Count0   (Count0),
        .Count1   (Count1)
`endif
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; InValid = 1'b0; InData = '0; InSel = 1'b0;
        Out0Ready = 1'b0; Out1Ready = 1'b0;
        tick();
        tick();
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL reset_inready got=%b exp=0", InReady); end
        Reset = 1'b1;
        #1;
        vectors++; if (Out0Valid !== 1'b0) begin miscompares++; $display("FAIL reset_out0valid got=%b exp=0", Out0Valid); end
        vectors++; if (Out1Valid !== 1'b0) begin miscompares++; $display("FAIL reset_out1valid got=%b exp=0", Out1Valid); end
        InSel = 1'b0; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL idle_inready_sel0 got=%b exp=1", InReady); end
        InSel = 1'b1; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL idle_inready_sel1 got=%b exp=1", InReady); end
        tick();
    endtask

    task automatic test_single_route();
        InValid = 1'b1; InSel = 1'b1; InData = 24'hABCDEF; Out1Ready = 1'b1;
        #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL single_inready got=%b exp=1", InReady); end
        tick();
        InValid = 1'b0;
        vectors++; if (Out1Valid !== 1'b1) begin miscompares++; $display("FAIL single_out1valid got=%b exp=1", Out1Valid); end
        vectors++; if (Out1Data !== 24'hABCDEF) begin miscompares++; $display("FAIL single_out1data got=%h exp=abcdef", Out1Data); end
        vectors++; if (Out0Valid !== 1'b0) begin miscompares++; $display("FAIL single_out0valid got=%b exp=0", Out0Valid); end
        tick();
        vectors++; if (Out1Valid !== 1'b0) begin miscompares++; $display("FAIL single_out1drained got=%b exp=0", Out1Valid); end
        Out1Ready = 1'b0;
    endtask

    task automatic test_backpressure();
        Out0Ready = 1'b0; InValid = 1'b1; InSel = 1'b0;
        InData = 24'h000001; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL bp_accept1 got=%b exp=1", InReady); end
        tick();
        InData = 24'h000002; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL bp_accept2 got=%b exp=1", InReady); end
        tick();
        InData = 24'h000003; #1;
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL bp_full_sel0 got=%b exp=0", InReady); end
        InSel = 1'b1; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL bp_full_sel1 got=%b exp=1", InReady); end
        InSel = 1'b0; #1;
        vectors++; if (Out0Data !== 24'h000001) begin miscompares++; $display("FAIL bp_head got=%h exp=000001", Out0Data); end
        // A pop in the same cycle must not open InReady on a full FIFO.
        Out0Ready = 1'b1; #1;
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL bp_full_with_pop got=%b exp=0", InReady); end
    endtask

    task automatic test_drain();
        // Entry state: FIFO0 full (1,2), Out0Ready=1, InValid=1 with 3.
        tick(); // pops 000001, push refused
        vectors++; if (Out0Data !== 24'h000002) begin miscompares++; $display("FAIL drain_second got=%h exp=000002", Out0Data); end
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL drain_ready_at1 got=%b exp=1", InReady); end
        tick(); // pushes 000003 and pops 000002
        InValid = 1'b0;
        vectors++; if (Out0Valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid3 got=%b exp=1", Out0Valid); end
        vectors++; if (Out0Data !== 24'h000003) begin miscompares++; $display("FAIL drain_third got=%h exp=000003", Out0Data); end
        // Count stayed at 1, so the FIFO is still not full.
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL drain_count_held got=%b exp=1", InReady); end
        tick();
        vectors++; if (Out0Valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got=%b exp=0", Out0Valid); end
    endtask

    task automatic test_interleave();
        logic [23:0] data;
        Out0Ready = 1'b1; Out1Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data    = 24'h000100 + 24'(i);
            InValid = 1'b1;
            InSel   = (i % 2 == 1);
            InData  = data;
            #1;
            vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL il_ready beat=%0d got=%b exp=1", i, InReady); end
            tick();
            if (i % 2 == 0) begin
                vectors++; if (Out0Valid !== 1'b1 || Out0Data !== data) begin miscompares++; $display("FAIL il_out0 beat=%0d got=%b/%h exp=1/%h", i, Out0Valid, Out0Data, data); end
                vectors++; if (Out1Valid !== 1'b0) begin miscompares++; $display("FAIL il_out1_idle beat=%0d got=%b exp=0", i, Out1Valid); end
            end else begin
                vectors++; if (Out1Valid !== 1'b1 || Out1Data !== data) begin miscompares++; $display("FAIL il_out1 beat=%0d got=%b/%h exp=1/%h", i, Out1Valid, Out1Data, data); end
                vectors++; if (Out0Valid !== 1'b0) begin miscompares++; $display("FAIL il_out0_idle beat=%0d got=%b exp=0", i, Out0Valid); end
            end
        end
        InValid = 1'b0;
        tick();
        vectors++; if (Out0Valid !== 1'b0 || Out1Valid !== 1'b0) begin miscompares++; $display("FAIL il_drained got=%b%b exp=00", Out0Valid, Out1Valid); end
    endtask

    task automatic test_reset_mid();
        Out0Ready = 1'b0; Out1Ready = 1'b0; InValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            InSel  = (i >= 2);
            InData = 24'h00A000 + 24'(i);
            tick();
        end
        InValid = 1'b0;
        vectors++; if (Out0Valid !== 1'b1 || Out0Data !== 24'h00A000) begin miscompares++; $display("FAIL mid_pre_out0 got=%b/%h exp=1/00a000", Out0Valid, Out0Data); end
        vectors++; if (Out1Valid !== 1'b1 || Out1Data !== 24'h00A002) begin miscompares++; $display("FAIL mid_pre_out1 got=%b/%h exp=1/00a002", Out1Valid, Out1Data); end
        InSel = 1'b0; #1;
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL mid_full0 got=%b exp=0", InReady); end
`ifdef DEMUX_STATS_EN
        // Pops so far: port 0 = 3 (drain) + 4 (interleave), port 1 = 1 + 4.
        vectors++; if (Count0 !== 16'd7) begin miscompares++; $display("FAIL stats_count0 got=%0d exp=7", Count0); end
        vectors++; if (Count1 !== 16'd5) begin miscompares++; $display("FAIL stats_count1 got=%0d exp=5", Count1); end
`endif
        Reset = 1'b0; #1;
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL mid_reset_inready got=%b exp=0", InReady); end
        tick();
        vectors++; if (Out0Valid !== 1'b0 || Out1Valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valids got=%b%b exp=00", Out0Valid, Out1Valid); end
`ifdef DEMUX_STATS_EN
        vectors++; if (Count0 !== 16'd0 || Count1 !== 16'd0) begin miscompares++; $display("FAIL stats_cleared got=%0d/%0d exp=0/0", Count0, Count1); end
`endif
        Reset = 1'b1; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got=%b exp=1", InReady); end
        tick();
        vectors++; if (Out0Valid !== 1'b0 || Out1Valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valids got=%b%b exp=00", Out0Valid, Out1Valid); end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_backpressure();
        test_drain();
        test_interleave();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
